uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clk cycles per serial bit (1 = clk runs at bit rate); legal range 1..65535.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-003 Port clk  input  1  single clock, all state on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port tx_data  input  8  byte to transmit, sampled on accept.
REQ-006 Port tx_valid  input  1  tx_data valid.
REQ-007 Port tx_ready  output  1  holding register empty, byte can be accepted.
REQ-008 Port tx_out  output  1  serial line, idle high, registered.
REQ-009 Port tx_busy  output  1  frame in progress on tx_out.

Function
REQ-010 Accept occurs on a rising edge where tx_valid && tx_ready; tx_data copies into a one-entry holding register and tx_ready deasserts on that edge.
REQ-011 tx_valid while tx_ready low is ignored; no byte lost or overwritten.
REQ-012 Frame order: start bit (0), data bits 0..7 LSB first, parity bit when UART_TX_PARITY_EN is defined, STOP_BITS stop bits (1).
REQ-013 Every bit held on tx_out for exactly CLKS_PER_BIT cycles.
REQ-014 State machine states IDLE, START, DATA, PARITY, STOP; IDLE->START when holding register full; START->DATA after one bit time; DATA->PARITY (or STOP without parity) after bit 7; PARITY->STOP; STOP->START if holding register full at end of last stop bit, else IDLE.
REQ-015 On IDLE->START the holding register moves into the shift register and tx_ready reasserts on the same edge.
REQ-016 Latency: byte accepted at edge N with shifter idle -> start bit visible on tx_out after edge N+1.
REQ-017 Back-to-back: byte waiting at end of last stop bit -> next start bit begins on the following cycle; no idle gap.
REQ-018 tx_busy high from first cycle of start bit through last cycle of last stop bit; low in IDLE.
REQ-019 tx_out = 1 in IDLE and during stop bits.
REQ-020 Bit-time counter wraps to 0 on reaching CLKS_PER_BIT-1; bit index counter 3 bits, wraps after bit 7.
REQ-021 Accept in the same cycle the holding register empties into the shifter is legal: tx_ready is high that cycle and the new byte is stored.

Reset
REQ-022 rst_n low asynchronously forces state IDLE, tx_out=1, tx_ready=1, tx_busy=0, counters 0, holding register empty.
REQ-023 Reset mid-frame aborts the frame, discards both shift and holding contents; line returns high immediately.
REQ-024 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: even parity bit (XOR of 8 data bits) inserted after bit 7; frame length 10+STOP_BITS bits.
REQ-026 UART_TX_PARITY_EN undefined: PARITY state and logic absent; frame length 9+STOP_BITS bits.

Structure
REQ-027 Shared package uart_pkg holds state encoding (IDLE, START, DATA, PARITY, STOP), data width 8, and START/STOP bit level constants, for reuse by the receiver.
REQ-028 Bit-time counter in sub-module uart_baud_tick: enable input, one-cycle tick output every CLKS_PER_BIT cycles, restart on frame start.

Verification
REQ-029 CLKS_PER_BIT=1, no parity, send 0x55 -> tx_out 0,1,0,1,0,1,0,1,0,1 then 1; tx_busy high 10 cycles.
REQ-030 CLKS_PER_BIT=4, send 0xA3 -> each bit held 4 cycles, data sequence 1,1,0,0,0,1,0,1; 40-cycle tx_busy pulse.
REQ-031 Parity enabled, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0.
REQ-032 tx_valid held high with 0x01 then 0x02 -> two frames, second start bit directly after first stop bit, no idle cycle; tx_ready low while holding full.
REQ-033 STOP_BITS=2, send 0xFF -> two high stop bit times before next start; 11 bit times per frame.
REQ-034 rst_n pulsed low during data bit 4 -> tx_out=1, tx_ready=1, tx_busy=0 immediately; next accepted byte sent as a complete clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int   DATA_W    = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: tick is high during the last clk cycle of each bit time.
// restart re-aligns the count to the start of a new frame.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_r;
  logic        tick_r;

  // Count clk cycles within a bit; tick_r flags the cycle where cnt_r == LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= 16'd0;
      tick_r <= (LAST == 16'd0);
    end else if (restart || !en) begin
      cnt_r  <= 16'd0;
      tick_r <= (LAST == 16'd0);
    end else if (cnt_r == LAST) begin
      cnt_r  <= 16'd0;
      tick_r <= (LAST == 16'd0);
    end else begin
      cnt_r  <= cnt_r + 16'd1;
      tick_r <= ((cnt_r + 16'd1) == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with one-entry holding register and back-to-back framing.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy
);

  uart_state_e       state_r;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] hold_data_r;
  logic              tx_ready_r;
  logic [2:0]        bit_idx_r;
  logic              stop_idx_r;
  logic              tx_out_r;
  logic              tx_busy_r;
`ifdef UART_TX_PARITY_EN
  logic              parity_r;
`endif

  logic tick_s;
  logic accept_s;
  logic last_stop_s;
  logic load_s;

  // Handshake and shifter-load decisions; load can only happen with the holding register full.
  always_comb begin
    accept_s    = tx_valid && tx_ready_r;
    last_stop_s = (stop_idx_r == 1'(STOP_BITS - 1));
    load_s      = !tx_ready_r &&
                  ((state_r == IDLE) || ((state_r == STOP) && tick_s && last_stop_s));
  end

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_r != IDLE),
    .restart (load_s),
    .tick    (tick_s)
  );

  // Holding register: filled on accept, emptied when the shifter takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_r <= 8'h00;
      tx_ready_r  <= 1'b1;
    end else if (accept_s) begin
      hold_data_r <= tx_data;
      tx_ready_r  <= 1'b0;
    end else if (load_s) begin
      tx_ready_r  <= 1'b1;
    end else begin
      tx_ready_r  <= tx_ready_r;
    end
  end

  // Frame state machine; tx_out/tx_busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      tx_out_r   <= STOP_BIT;
      tx_busy_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else if (load_s) begin
      state_r    <= START;
      shift_r    <= hold_data_r;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      tx_out_r   <= START_BIT;
      tx_busy_r  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r   <= even_parity(hold_data_r);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          tx_out_r  <= STOP_BIT;
          tx_busy_r <= 1'b0;
        end
        START: begin
          if (tick_s) begin
            state_r   <= DATA;
            tx_out_r  <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_idx_r <= 3'd0;
          end
        end
        DATA: begin
          if (tick_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r    <= PARITY;
              tx_out_r   <= parity_r;
`else
              state_r    <= STOP;
              tx_out_r   <= STOP_BIT;
              stop_idx_r <= 1'b0;
`endif
            end else begin
              tx_out_r <= shift_r[0];
              shift_r  <= {1'b0, shift_r[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            state_r    <= STOP;
            tx_out_r   <= STOP_BIT;
            stop_idx_r <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (tick_s) begin
            if (last_stop_s) begin
              state_r   <= IDLE;
              tx_out_r  <= STOP_BIT;
              tx_busy_r <= 1'b0;
            end else begin
              stop_idx_r <= stop_idx_r + 1'b1;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          tx_out_r  <= STOP_BIT;
          tx_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_r;
  assign tx_out   = tx_out_r;
  assign tx_busy  = tx_busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (1 clk/bit, 4 clks/bit, 2 stop bits).
// Expected line sequences are written out by hand, first transmitted bit at the MSB.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] d     [3];
  logic       v     [3];
  logic       rdy   [3];
  logic       line  [3];
  logic       busy  [3];

  int         n_tests;
  int         n_fail;
  logic [63:0] got;
  int          busy_cnt;

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(d[0]), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .tx_out(line[0]), .tx_busy(busy[0]));

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(d[1]), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .tx_out(line[1]), .tx_busy(busy[1]));

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .tx_data(d[2]), .tx_valid(v[2]),
    .tx_ready(rdy[2]), .tx_out(line[2]), .tx_busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for a single rising edge; returns at the negedge after it.
  task automatic send(input int sel, input logic [7:0] b);
    d[sel] = b;
    v[sel] = 1'b1;
    @(negedge clk);
    v[sel] = 1'b0;
  endtask

  task automatic sample(input int sel);
    got      = {got[62:0], line[sel]};
    busy_cnt = busy_cnt + int'(busy[sel]);
  endtask

  task automatic collect(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(sel);
    end
  endtask

  function automatic logic [63:0] expand(input logic [63:0] seq, input int nbits, input int k);
    logic [63:0] r;
    r = 64'd0;
    for (int i = nbits - 1; i >= 0; i--)
      for (int j = 0; j < k; j++)
        r = {r[62:0], seq[i]};
    return r;
  endfunction

  // tx_valid held across two bytes; a third value is offered while the holding register is full.
  task automatic b2b(input int sel, input string tag, input logic [7:0] b0, input logic [7:0] b1,
                     input int n, input logic [63:0] exp_line, input int exp_busy);
    got      = 64'd0;
    busy_cnt = 0;
    d[sel]   = b0;
    v[sel]   = 1'b1;
    @(negedge clk);
    check({tag, "_ready_full0"}, 64'(rdy[sel]), 64'd0);
    d[sel] = b1;
    @(negedge clk);
    sample(sel);
    check({tag, "_ready_after_load"}, 64'(rdy[sel]), 64'd1);
    @(negedge clk);
    sample(sel);
    check({tag, "_ready_full1"}, 64'(rdy[sel]), 64'd0);
    d[sel] = 8'hAA;
    @(negedge clk);
    sample(sel);
    v[sel] = 1'b0;
    collect(sel, n - 3);
    check({tag, "_line"}, got, exp_line);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'h00;
      v[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_out",   64'(line[0]), 64'd1);
    check("rst_ready", 64'(rdy[0]),  64'd1);
    check("rst_busy",  64'(busy[0]), 64'd0);
    rst_n = 1'b1;

    // 0x55 at one clk per bit, accepted on the first edge after reset.
    got = 64'd0; busy_cnt = 0;
    send(0, 8'h55);
    check("a55_ready_low", 64'(rdy[0]),  64'd0);
    check("a55_line_idle", 64'(line[0]), 64'd1);
`ifdef UART_TX_PARITY_EN
    collect(0, 12);
    check("a55_line", got, 64'(12'b0_10101010_0_1_1));
    check("a55_busy_cycles", 64'(busy_cnt), 64'd11);
`else
    collect(0, 11);
    check("a55_line", got, 64'(11'b0_10101010_1_1));
    check("a55_busy_cycles", 64'(busy_cnt), 64'd10);
`endif

    // 0xA3 at four clks per bit.
    got = 64'd0; busy_cnt = 0;
    send(1, 8'hA3);
`ifdef UART_TX_PARITY_EN
    collect(1, 48);
    check("b_a3_line", got, expand(64'(12'b0_11000101_0_1_1), 12, 4));
    check("b_a3_busy_cycles", 64'(busy_cnt), 64'd44);
`else
    collect(1, 44);
    check("b_a3_line", got, expand(64'(11'b0_11000101_1_1), 11, 4));
    check("b_a3_busy_cycles", 64'(busy_cnt), 64'd40);
`endif

    // Back-to-back frames, then two stop bits back-to-back.
`ifdef UART_TX_PARITY_EN
    b2b(0, "a_b2b", 8'h01, 8'h02, 23, 64'(23'b0_10000000_1_1_0_01000000_1_1_1), 22);
    b2b(2, "c_stop2", 8'hFF, 8'hFF, 25, 64'(25'b0_11111111_0_1_1_0_11111111_0_1_1_1), 24);
`else
    b2b(0, "a_b2b", 8'h01, 8'h02, 21, 64'(21'b0_10000000_1_0_01000000_1_1), 20);
    b2b(2, "c_stop2", 8'hFF, 8'hFF, 23, 64'(23'b0_11111111_1_1_0_11111111_1_1_1), 22);
`endif

    // Parity bit values (frame without parity when the feature is off).
    got = 64'd0; busy_cnt = 0;
    send(0, 8'h07);
`ifdef UART_TX_PARITY_EN
    collect(0, 12);
    check("par07_line", got, 64'(12'b0_11100000_1_1_1));
`else
    collect(0, 11);
    check("par07_line", got, 64'(11'b0_11100000_1_1));
`endif
    got = 64'd0; busy_cnt = 0;
    send(0, 8'h03);
`ifdef UART_TX_PARITY_EN
    collect(0, 12);
    check("par03_line", got, 64'(12'b0_11000000_0_1_1));
`else
    collect(0, 11);
    check("par03_line", got, 64'(11'b0_11000000_1_1));
`endif

    // Reset during data bit 4 of 0x0F (a low bit), then a clean frame.
    got = 64'd0; busy_cnt = 0;
    send(0, 8'h0F);
    collect(0, 5);
    @(negedge clk);
    check("rst_mid_bit4", 64'(line[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out",   64'(line[0]), 64'd1);
    check("rst_mid_ready", 64'(rdy[0]),  64'd1);
    check("rst_mid_busy",  64'(busy[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got = 64'd0; busy_cnt = 0;
    send(0, 8'h3C);
`ifdef UART_TX_PARITY_EN
    collect(0, 12);
    check("post_rst_line", got, 64'(12'b0_00111100_0_1_1));
    check("post_rst_busy_cycles", 64'(busy_cnt), 64'd11);
`else
    collect(0, 11);
    check("post_rst_line", got, 64'(11'b0_00111100_1_1));
    check("post_rst_busy_cycles", 64'(busy_cnt), 64'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
